// File: rtl/bv4_inv_arbiter.sv
// rtl/bv4_inv_arbiter.sv - round-robin arbiter sharing one GF(2^4) inverter
// Inverter uses the GF((2^2)^2) normal-basis tower: nibble {g1,g0} = g1*Z^4 + g0*Z, GF(4) basis (W^2, W).

module bv4_inv (
    input  logic [3:0] a,
    output logic [3:0] y
);

    function automatic logic [1:0] gf4_mul(input logic [1:0] p, input logic [1:0] q);
        logic e;
        e = (p[1] ^ p[0]) & (q[1] ^ q[0]);
        return {(p[1] & q[1]) ^ e, (p[0] & q[0]) ^ e};
    endfunction

    // Square then scale by N = W^2
    function automatic logic [1:0] gf4_sq_scl(input logic [1:0] c);
        return {c[1], c[1] ^ c[0]};
    endfunction

    logic [1:0] g1;
    logic [1:0] g0;
    logic [1:0] theta;
    logic [1:0] theta_inv;

    assign g1        = a[3:2];
    assign g0        = a[1:0];
    assign theta     = gf4_sq_scl(g1 ^ g0) ^ gf4_mul(g1, g0);
    assign theta_inv = {theta[0], theta[1]};
    assign y         = {gf4_mul(theta_inv, g0), gf4_mul(theta_inv, g1)};

endmodule

module bv4_inv_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       in_clock,
    input  logic                       in_reset,
    input  logic [NUM_REQ-1:0]         in_req_valid,
    input  logic [4*NUM_REQ-1:0]       in_req_data,
    output logic [NUM_REQ-1:0]         out_req_ready,
    output logic                       out_rsp_valid,
    output logic [3:0]                 out_rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] out_rsp_id,
    input  logic                       in_rsp_ready
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] ptr_next;
    logic            grant_any;
    logic            slot_free;
    logic            accept;
    logic [3:0]      operand;
    logic [3:0]      operand_inv;
    int              cand;

    assign slot_free = !out_rsp_valid || in_rsp_ready;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && in_req_valid[ID_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    assign accept        = grant_any && slot_free && !in_reset;
    assign out_req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign ptr_next      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign operand       = in_req_data[{grant_idx, 2'b00} +: 4];

    bv4_inv u_inv (
        .a (operand),
        .y (operand_inv)
    );

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_rsp_valid <= 1'b0;
            out_rsp_data  <= 4'h0;
            out_rsp_id    <= '0;
            ptr           <= '0;
        end else if (accept) begin
            out_rsp_valid <= 1'b1;
            out_rsp_data  <= operand_inv;
            out_rsp_id    <= grant_idx;
            ptr           <= ptr_next;
        end else if (in_rsp_ready) begin
            out_rsp_valid <= 1'b0;
        end
    end

endmodule
